// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: glitch-free divided-clock controller with shadowed config, start/stop and one-shot (optional CLKDIV_CTRL_PCOUNT_EN adds period_count)
module clkdiv_ctrl #(
  parameter int WIDTH = 8,
  parameter int PCNT_W = 8,
  parameter int DEFAULT_COMPARE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_compare,
  input  logic              cfg_oneshot,
  input  logic [PCNT_W-1:0] cfg_pulses,
  input  logic              start,
  input  logic              stop,
  output logic              out_clk,
  output logic              tick,
  output logic              busy,
  output logic              done
`ifdef CLKDIV_CTRL_PCOUNT_EN
  ,output logic [PCNT_W-1:0] period_count
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cmp_q, cmp_d, sh_cmp_q, sh_cmp_d;
  logic [PCNT_W-1:0] pul_q, pul_d, sh_pul_q, sh_pul_d, pc_q, pc_d, pc_inc;
  logic out_q, out_d, done_q, done_d, os_q, os_d, sh_os_q, sh_os_d, shv_q, shv_d;
  logic idle, term, fall, fin, xfer, apply;
  assign idle = state_q == IDLE;
  assign term = !idle && cnt_q == cmp_q;
  assign fall = term && out_q;
  assign pc_inc = &pc_q ? pc_q : pc_q + 1'b1;
  // a stop with out_clk low ends at once; otherwise the run ends on a falling toggle
  assign fin = !idle && ((fall && ((os_q && pc_inc == pul_q) || state_q == STOPPING || stop))
                         || (state_q == RUN && stop && !out_q));
  assign cfg_ready = idle || !shv_q;
  assign xfer = cfg_valid && cfg_ready;
  assign apply = shv_q && (term || fin);
  assign out_clk = out_q;
  assign tick = term;
  assign busy = !idle;
  assign done = done_q;
`ifdef CLKDIV_CTRL_PCOUNT_EN
  assign period_count = pc_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    out_d = out_q;
    done_d = 1'b0;
    pc_d = pc_q;
    cmp_d = apply ? sh_cmp_q : cmp_q;
    os_d = apply ? sh_os_q : os_q;
    pul_d = apply ? sh_pul_q : pul_q;
    shv_d = shv_q && !apply;
    sh_cmp_d = sh_cmp_q;
    sh_os_d = sh_os_q;
    sh_pul_d = sh_pul_q;
    if (idle) begin
      if (xfer) begin
        cmp_d = cfg_compare;
        os_d = cfg_oneshot;
        pul_d = cfg_pulses;
      end
      if (start && !stop) begin
        pc_d = '0;
        cnt_d = '0;
        out_d = 1'b0;
        if (os_d && pul_d == '0) done_d = 1'b1;
        else state_d = RUN;
      end
    end else begin
      if (xfer) begin
        sh_cmp_d = cfg_compare;
        sh_os_d = cfg_oneshot;
        sh_pul_d = cfg_pulses;
        shv_d = 1'b1;
      end
      cnt_d = term ? '0 : cnt_q + 1'b1;
      out_d = term ? !out_q : out_q;
      if (fall) pc_d = pc_inc;
      if (fin) begin
        state_d = IDLE;
        cnt_d = '0;
        out_d = 1'b0;
        done_d = 1'b1;
        shv_d = 1'b0;
        if (xfer) begin
          cmp_d = cfg_compare;
          os_d = cfg_oneshot;
          pul_d = cfg_pulses;
        end
      end else if (state_q == RUN && stop) begin
        state_d = STOPPING;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_q <= 1'b0;
      done_q <= 1'b0;
      pc_q <= '0;
      cmp_q <= WIDTH'(DEFAULT_COMPARE);
      os_q <= 1'b0;
      pul_q <= '0;
      shv_q <= 1'b0;
      sh_cmp_q <= '0;
      sh_os_q <= 1'b0;
      sh_pul_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      done_q <= done_d;
      pc_q <= pc_d;
      cmp_q <= cmp_d;
      os_q <= os_d;
      pul_q <= pul_d;
      shv_q <= shv_d;
      sh_cmp_q <= sh_cmp_d;
      sh_os_q <= sh_os_d;
      sh_pul_q <= sh_pul_d;
    end
  end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: scoreboard bench; stimulus queues expected out_clk edges and done pulses, a monitor matches them
module tb_clkdiv_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, cfg_oneshot = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] cfg_compare = 8'd0, cfg_pulses = 8'd0;
  logic cfg_ready, out_clk, tick, busy, done;
`ifdef CLKDIV_CTRL_PCOUNT_EN
  logic [7:0] period_count;
`endif
  int cyc = 0, n_chk = 0, n_fail = 0, s;
  typedef struct {int kind; int val; int cy;} ev_t;
  ev_t q[$];
  logic prev_out = 1'b0;

  clkdiv_ctrl #(.WIDTH(8), .PCNT_W(8), .DEFAULT_COMPARE(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_compare(cfg_compare), .cfg_oneshot(cfg_oneshot), .cfg_pulses(cfg_pulses),
    .start(start), .stop(stop), .out_clk(out_clk), .tick(tick), .busy(busy), .done(done)
`ifdef CLKDIV_CTRL_PCOUNT_EN
    , .period_count(period_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int v, input int cy);
    ev_t e;
    e.kind = k;
    e.val = v;
    e.cy = cy;
    q.push_back(e);
  endtask

  task automatic see(input int k, input int v);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected none", k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val != v || e.cy != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                 k, v, cyc, e.kind, e.val, e.cy);
      end
    end
  endtask

  // kind 0 = out_clk changed to val, kind 1 = done pulse
  always @(negedge clk) begin
    if (out_clk !== prev_out) begin
      see(0, int'(out_clk));
      prev_out = out_clk;
    end
    if (done === 1'b1) see(1, 1);
  end

  task automatic nx;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg(input int c, input logic os, input int p);
    cfg_compare = 8'(c);
    cfg_oneshot = os;
    cfg_pulses = 8'(p);
    cfg_valid = 1'b1;
    nx();
  endtask

  task automatic go(output int st);
    start = 1'b1;
    st = cyc + 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", out_clk, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tick", tick, 0);
    chk("reset_ready", cfg_ready, 1);
    rst_n = 1'b1;
    nx();
    // basic run at compare=3, stop while low
    cfg(3, 1'b0, 0);
    go(s);
    push(0, 1, s + 4); push(0, 0, s + 8); push(0, 1, s + 12); push(0, 0, s + 16);
    nx();
    chk("run_busy", busy, 1);
    at(s + 2); chk("tick_low", tick, 0);
    at(s + 3); chk("tick_high", tick, 1);
    at(s + 17);
    stop = 1'b1;
    push(1, 1, s + 18);
    nx();
    chk("stop_low_busy", busy, 0);
    chk("stop_low_out", out_clk, 0);
    // shadowed compare change during high phase
    go(s);
    push(0, 1, s + 4); push(0, 0, s + 8); push(0, 1, s + 10); push(0, 0, s + 12);
    push(0, 1, s + 14); push(0, 0, s + 16);
    nx();
    at(s + 5);
    chk("ready_before", cfg_ready, 1);
    cfg_compare = 8'd1;
    cfg_valid = 1'b1;
    nx();
    chk("ready_shadow_full", cfg_ready, 0);
    at(s + 7); chk("ready_until_term", cfg_ready, 0);
    at(s + 8); chk("ready_after_apply", cfg_ready, 1);
    at(s + 16);
    stop = 1'b1;
    push(1, 1, s + 17);
    nx();
    // one-shot of 3 periods at compare=0
    cfg(0, 1'b1, 3);
    go(s);
    push(0, 1, s + 1); push(0, 0, s + 2); push(0, 1, s + 3); push(0, 0, s + 4);
    push(0, 1, s + 5); push(0, 0, s + 6); push(1, 1, s + 6);
    nx();
    chk("oneshot_tick", tick, 1);
    at(s + 6); chk("oneshot_busy_end", busy, 0);
    at(s + 8); chk("oneshot_idle_out", out_clk, 0);
    // one-shot with zero pulses
    cfg(0, 1'b1, 0);
    go(s);
    push(1, 1, s);
    nx();
    chk("zero_pulse_busy", busy, 0);
    nx();
    // stop while high completes the high phase
    cfg(3, 1'b0, 0);
    go(s);
    push(0, 1, s + 4); push(0, 0, s + 8); push(1, 1, s + 8);
    nx();
    at(s + 5);
    stop = 1'b1;
    nx();
    chk("stopping_busy", busy, 1);
    chk("stopping_out_high", out_clk, 1);
    at(s + 8); chk("stop_high_busy", busy, 0);
    at(s + 10); chk("stop_high_out", out_clk, 0);
    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    nx();
    chk("start_stop_busy", busy, 0);
    chk("start_stop_out", out_clk, 0);
    nx();
    // asynchronous reset during high phase, then default compare restored
    cfg(1, 1'b0, 0);
    go(s);
    push(0, 1, s + 2); push(0, 0, s + 4);
    nx();
    at(s + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", out_clk, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nx();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_ready", cfg_ready, 1);
    go(s);
    push(0, 1, s + 4); push(0, 0, s + 8); push(1, 1, s + 10);
    nx();
    at(s + 9);
    stop = 1'b1;
    nx();
`ifdef CLKDIV_CTRL_PCOUNT_EN
    // 300 periods saturate the 8-bit period count
    cfg(0, 1'b0, 0);
    go(s);
    for (int k = 0; k < 300; k++) begin
      push(0, 1, s + 1 + 2 * k);
      push(0, 0, s + 2 + 2 * k);
    end
    push(1, 1, s + 601);
    nx();
    chk("pcount_clear", period_count, 0);
    at(s + 600);
    stop = 1'b1;
    nx();
    chk("pcount_sat", period_count, 255);
`endif
    repeat (5) nx();
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_event: got nothing, expected kind=%0d val=%0d cycle=%0d", e.kind, e.val, e.cy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
